pipelined_fault_secure_csa_adder: RTL and testbench



---
 rtl/csa_fs_pkg.sv | 32 +++
 rtl/csa_fs_block_dual.sv | 55 +++++
 rtl/pipelined_fault_secure_csa_adder.sv | 183 ++++++++++++++++++
 tb/tb_pipelined_fault_secure_csa_adder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_fs_pkg.sv
// Shared types and helpers for the fault-secure carry-select adder.
package csa_fs_pkg;

    typedef enum logic [1:0] {
        FI_NONE   = 2'd0,
        FI_SUM    = 2'd1,
        FI_SUMINV = 2'd2,
        FI_PAR    = 2'd3
    } fi_sel_e;

    typedef struct packed {
        logic    vld;
        logic    pa;
        logic    pb;
        fi_sel_e fi;
    } s1_meta_t;

    typedef struct packed {
        logic    vld;
        logic    pa;
        logic    pb;
        fi_sel_e fi;
        logic    chk_in;
    } s2_meta_t;

    localparam int PAR_MAX_W = 1024;

    function automatic logic parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/csa_fs_block_dual.sv
// One carry-select block computing both cin candidates on a true rail and on a
// complemented rail (~a,~b inputs) with its own carry chain.
module csa_block_dual #(
    parameter int BLK_W = 13
) (
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    output logic [BLK_W-1:0] t_sum0,
    output logic [BLK_W-1:0] t_sum1,
    output logic             t_c0,
    output logic             t_c1,
    output logic [BLK_W-1:0] i_sum0,
    output logic [BLK_W-1:0] i_sum1,
    output logic             i_c0,
    output logic             i_c1,
    output logic [BLK_W-1:0] i_cv0,
    output logic [BLK_W-1:0] i_cv1
);

    // Majority is self-dual, so the complemented rail uses the same cell on
    // inverted operands; suffix 0/1 always refers to the true-rail cin.
    always_comb begin
        logic             tc0, tc1, nc0, nc1;
        logic [BLK_W-1:0] na, nb;
        na     = ~a;
        nb     = ~b;
        tc0    = 1'b0;
        tc1    = 1'b1;
        nc0    = 1'b1;
        nc1    = 1'b0;
        t_sum0 = '0;
        t_sum1 = '0;
        i_sum0 = '0;
        i_sum1 = '0;
        i_cv0  = '0;
        i_cv1  = '0;
        for (int i = 0; i < BLK_W; i++) begin
            t_sum0[i] = a[i] ^ b[i] ^ tc0;
            t_sum1[i] = a[i] ^ b[i] ^ tc1;
            tc0       = (a[i] & b[i]) | (a[i] & tc0) | (b[i] & tc0);
            tc1       = (a[i] & b[i]) | (a[i] & tc1) | (b[i] & tc1);
            i_cv0[i]  = nc0;
            i_cv1[i]  = nc1;
            i_sum0[i] = na[i] ^ nb[i] ^ nc0;
            i_sum1[i] = na[i] ^ nb[i] ^ nc1;
            nc0       = (na[i] & nb[i]) | (na[i] & nc0) | (nb[i] & nc0);
            nc1       = (na[i] & nb[i]) | (na[i] & nc1) | (nb[i] & nc1);
        end
        t_c0 = tc0;
        t_c1 = tc1;
        i_c0 = nc0;
        i_c1 = nc1;
    end

endmodule

// File: rtl/pipelined_fault_secure_csa_adder.sv
// Three-stage fault-secure carry-select adder: dual complementary rails,
// input parity check, sum parity prediction and error accounting.
module pipelined_fault_secure_csa_adder
    import csa_fs_pkg::*;
#(
    parameter int WIDTH = 78,
    parameter int BLK_W = 13,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             pa,
    input  logic             pb,
    input  logic [1:0]       fi_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] s_inv,
    output logic             cout,
    output logic             cout_inv,
    output logic             p_pred,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_err
);

    localparam int NBLK = WIDTH / BLK_W;

    if (WIDTH % BLK_W != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of BLK_W");
    end

    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // Stage 1: operand capture
    logic [WIDTH-1:0] a1_q, b1_q;
    s1_meta_t         m1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q <= '0;
            b1_q <= '0;
            m1_q <= '0;
        end else if (en) begin
            a1_q <= a;
            b1_q <= b;
            m1_q <= '{vld: in_valid, pa: pa, pb: pb, fi: fi_sel_e'(fi_sel)};
        end
    end

    // Stage 2: per-block candidates on both rails
    logic [NBLK-1:0][BLK_W-1:0] ts0, ts1, is0, is1, icv0, icv1;
    logic [NBLK-1:0]            tc0, tc1, ic0, ic1, cp0, cp1;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        csa_block_dual #(.BLK_W(BLK_W)) u_blk (
            .a      (a1_q[k*BLK_W +: BLK_W]),
            .b      (b1_q[k*BLK_W +: BLK_W]),
            .t_sum0 (ts0[k]),
            .t_sum1 (ts1[k]),
            .t_c0   (tc0[k]),
            .t_c1   (tc1[k]),
            .i_sum0 (is0[k]),
            .i_sum1 (is1[k]),
            .i_c0   (ic0[k]),
            .i_c1   (ic1[k]),
            .i_cv0  (icv0[k]),
            .i_cv1  (icv1[k])
        );
        // Parity of the true internal carries, recovered from the inverted rail.
        assign cp0[k] = ^(~icv0[k]);
        assign cp1[k] = ^(~icv1[k]);
    end

    logic [NBLK-1:0][BLK_W-1:0] ts0_q, ts1_q, is0_q, is1_q;
    logic [NBLK-1:0]            tc0_q, tc1_q, ic0_q, ic1_q, cp0_q, cp1_q;
    s2_meta_t                   m2_q;
    logic                       chk_in;

    assign chk_in = (parity(PAR_MAX_W'(a1_q)) != m1_q.pa) |
                    (parity(PAR_MAX_W'(b1_q)) != m1_q.pb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts0_q <= '0; ts1_q <= '0; is0_q <= '0; is1_q <= '0;
            tc0_q <= '0; tc1_q <= '0; ic0_q <= '0; ic1_q <= '0;
            cp0_q <= '0; cp1_q <= '0;
            m2_q  <= '0;
        end else if (en) begin
            ts0_q <= ts0; ts1_q <= ts1; is0_q <= is0; is1_q <= is1;
            tc0_q <= tc0; tc1_q <= tc1; ic0_q <= ic0; ic1_q <= ic1;
            cp0_q <= cp0; cp1_q <= cp1;
            m2_q  <= '{vld: m1_q.vld, pa: m1_q.pa, pb: m1_q.pb, fi: m1_q.fi, chk_in: chk_in};
        end
    end

    // Stage 3: independent ripple select per rail, fault injection, checking
    logic [WIDTH-1:0] s_d, sinv_d;
    logic             cout_d, coutinv_d, ppred_d, err_d;

    always_comb begin
        logic tc, nc, cp;
        tc     = 1'b0;
        nc     = 1'b1;
        cp     = 1'b0;
        s_d    = '0;
        sinv_d = '0;
        for (int k = 0; k < NBLK; k++) begin
            s_d[k*BLK_W +: BLK_W]    = tc ? ts1_q[k] : ts0_q[k];
            sinv_d[k*BLK_W +: BLK_W] = nc ? is0_q[k] : is1_q[k];
            cp = cp ^ (nc ? cp0_q[k] : cp1_q[k]);
            tc = tc ? tc1_q[k] : tc0_q[k];
            nc = nc ? ic0_q[k] : ic1_q[k];
        end
        cout_d    = tc;
        coutinv_d = nc;
        ppred_d   = m2_q.pa ^ m2_q.pb ^ cp;
        unique case (m2_q.fi)
            FI_SUM:    s_d[0]    = ~s_d[0];
            FI_SUMINV: sinv_d[0] = ~sinv_d[0];
            FI_PAR:    ppred_d   = ~ppred_d;
            default:   ;
        endcase
        err_d = m2_q.chk_in | (s_d != ~sinv_d) | (cout_d != ~coutinv_d) |
                (parity(PAR_MAX_W'(s_d)) != ppred_d);
    end

    logic             vld3_q, cout_q, coutinv_q, ppred_q, err_q, sticky_q;
    logic [WIDTH-1:0] s_q, sinv_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld3_q    <= 1'b0;
            s_q       <= '0;
            sinv_q    <= '0;
            cout_q    <= 1'b0;
            coutinv_q <= 1'b0;
            ppred_q   <= 1'b0;
            err_q     <= 1'b0;
        end else if (en) begin
            vld3_q    <= m2_q.vld;
            s_q       <= s_d;
            sinv_q    <= sinv_d;
            cout_q    <= cout_d;
            coutinv_q <= coutinv_d;
            ppred_q   <= ppred_d;
            err_q     <= m2_q.vld & err_d;
        end
    end

    // Clear wins over a coincident erroneous handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (clr_err) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (vld3_q & out_ready & err_q) begin
            sticky_q <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid  = vld3_q;
    assign s          = s_q;
    assign s_inv      = sinv_q;
    assign cout       = cout_q;
    assign cout_inv   = coutinv_q;
    assign p_pred     = ppred_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_pipelined_fault_secure_csa_adder.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops and compares on each handshake.
module tb_pipelined_fault_secure_csa_adder;

    localparam int W  = 78;
    localparam int CW = 2;

    logic          clk, rst_n, in_valid, in_ready, pa, pb, out_valid, out_ready;
    logic [W-1:0]  a, b, s, s_inv;
    logic [1:0]    fi_sel;
    logic          cout, cout_inv, p_pred, err, err_sticky, clr_err;
    logic [CW-1:0] err_cnt;

    pipelined_fault_secure_csa_adder #(.WIDTH(W), .BLK_W(13), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .pa(pa), .pb(pb), .fi_sel(fi_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .s_inv(s_inv), .cout(cout), .cout_inv(cout_inv), .p_pred(p_pred),
        .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt), .clr_err(clr_err)
    );

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] si;
        logic         co, ci, pp, er;
        int           issue;
        bit           lat;
    } exp_t;

    exp_t         q[$];
    exp_t         me, e1;
    int           n_tests, n_fail, n_push, n_pop, cyc;
    logic [95:0]  r1, r2;
    logic [W-1:0] ones;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got %h required %h", nm, got, expv);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] sv, input logic [W-1:0] siv,
                                input logic co, input logic ci, input logic pp, input logic er);
        exp_t e;
        e.s = sv; e.si = siv; e.co = co; e.ci = ci; e.pp = pp; e.er = er;
        e.issue = 0; e.lat = 1'b1;
        return e;
    endfunction

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic pav, input logic pbv, input logic [1:0] fi);
        exp_t       e;
        logic [W:0] sum;
        sum   = {1'b0, av} + {1'b0, bv};
        e.s   = sum[W-1:0];
        e.co  = sum[W];
        e.si  = ~e.s;
        e.ci  = ~e.co;
        e.pp  = pav ^ pbv ^ (^av) ^ (^bv) ^ (^e.s);
        e.er  = (pav != ^av) | (pbv != ^bv) | (fi != 2'd0);
        if (fi == 2'd1) e.s[0]  = ~e.s[0];
        if (fi == 2'd2) e.si[0] = ~e.si[0];
        if (fi == 2'd3) e.pp    = ~e.pp;
        e.issue = 0;
        e.lat   = 1'b1;
        return e;
    endfunction

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic pav,
                        input logic pbv, input logic [1:0] fi, input exp_t e);
        int k;
        @(posedge clk); #1;
        a = av; b = bv; pa = pav; pb = pbv; fi_sel = fi; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            e.issue = cyc;
            q.push_back(e);
            n_push++;
        end
    endtask

    task automatic send_m(input logic [W-1:0] av, input logic [W-1:0] bv, input logic pav,
                          input logic pbv, input logic [1:0] fi, input bit lat);
        exp_t e;
        e = model(av, bv, pav, pbv, fi);
        e.lat = lat;
        send(av, bv, pav, pbv, fi, e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        fi_sel   = 2'd0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_pending", 128'(q.size()), 128'(0));
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_output s=%h required no output", s);
            end else begin
                me = q.pop_front();
                n_pop++;
                chk("s",        128'(s),        128'(me.s));
                chk("s_inv",    128'(s_inv),    128'(me.si));
                chk("cout",     128'(cout),     128'(me.co));
                chk("cout_inv", 128'(cout_inv), 128'(me.ci));
                chk("p_pred",   128'(p_pred),   128'(me.pp));
                chk("err",      128'(err),      128'(me.er));
                if (me.lat) chk("latency", 128'(cyc - me.issue), 128'(3));
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; n_push = 0; n_pop = 0;
        ones = '1;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; pa = 1'b0; pb = 1'b0;
        fi_sel = 2'd0; out_ready = 1'b1; clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid),  128'(0));
        chk("rst_s",         128'(s),          128'(0));
        chk("rst_s_inv",     128'(s_inv),      128'(0));
        chk("rst_err",       128'(err),        128'(0));
        chk("rst_sticky",    128'(err_sticky), 128'(0));
        chk("rst_cnt",       128'(err_cnt),    128'(0));
        rst_n = 1'b1;

        // Full carry chain: all-ones + 1
        send(ones, 78'd1, 1'b0, 1'b1, 2'd0, mk('0, ones, 1'b1, 1'b0, 1'b0, 1'b0));
        idle(); drain();

        // Wrong pa on 5 + 3
        send(78'd5, 78'd3, 1'b1, 1'b0, 2'd0, mk(78'd8, ~78'd8, 1'b0, 1'b1, 1'b0, 1'b1));
        idle(); drain();
        chk("sticky_after_bad_parity", 128'(err_sticky), 128'(1));
        chk("cnt_after_bad_parity",    128'(err_cnt),    128'(1));
        pulse_clr();

        // One beat per fault-injection point
        send('0, '0, 1'b0, 1'b0, 2'd1, mk(78'd1, ones,   1'b0, 1'b1, 1'b0, 1'b1));
        send('0, '0, 1'b0, 1'b0, 2'd2, mk('0, ~78'd1,    1'b0, 1'b1, 1'b0, 1'b1));
        send('0, '0, 1'b0, 1'b0, 2'd3, mk('0, ones,      1'b0, 1'b1, 1'b1, 1'b1));
        idle(); drain();
        chk("cnt_after_fi", 128'(err_cnt),    128'(3));
        chk("sticky_fi",    128'(err_sticky), 128'(1));
        pulse_clr();
        chk("cnt_cleared",    128'(err_cnt),    128'(0));
        chk("sticky_cleared", 128'(err_sticky), 128'(0));

        // Backpressure: three beats fill the pipe, hold for 5 cycles
        e1 = model(78'd1, 78'd2, 1'b1, 1'b1, 2'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_m(78'd1, 78'd2, 1'b1, 1'b1, 2'd0, 1'b0);
        send_m(78'd7, 78'd9, 1'b1, 1'b0, 2'd0, 1'b0);
        send_m(78'd1 << 77, 78'd1 << 77, 1'b1, 1'b1, 2'd0, 1'b0);
        idle();
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready",  128'(in_ready),  128'(0));
            chk("stall_out_valid", 128'(out_valid), 128'(1));
            chk("stall_s",         128'(s),         128'(e1.s));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();

        // Counter saturation at 2^CW-1
        for (int i = 0; i < 5; i++)
            send('0, '0, 1'b0, 1'b0, 2'd1, mk(78'd1, ones, 1'b0, 1'b1, 1'b0, 1'b1));
        idle(); drain();
        chk("cnt_saturated", 128'(err_cnt),    128'(3));
        chk("sticky_sat",    128'(err_sticky), 128'(1));
        pulse_clr();

        // Random fault-free traffic at full throughput
        for (int i = 0; i < 1000; i++) begin
            r1 = {$urandom(), $urandom(), $urandom()};
            r2 = {$urandom(), $urandom(), $urandom()};
            send_m(r1[W-1:0], r2[W-1:0], ^r1[W-1:0], ^r2[W-1:0], 2'd0, 1'b1);
        end
        idle(); drain();
        chk("cnt_after_random", 128'(err_cnt), 128'(0));

        // Asynchronous reset with results in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_m(78'd11, 78'd22, 1'b1, 1'b0, 2'd0, 1'b0);
        send_m(78'd33, 78'd44, 1'b0, 1'b1, 2'd0, 1'b0);
        send_m(78'd55, 78'd66, 1'b1, 1'b0, 2'd0, 1'b0);
        idle();
        chk("pre_reset_out_valid", 128'(out_valid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 128'(out_valid), 128'(0));
        chk("async_rst_s",         128'(s),         128'(0));
        chk("async_rst_in_ready",  128'(in_ready),  128'(1));
        n_push = n_push - q.size();
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_m(78'd100, 78'd200, 1'b1, 1'b0, 2'd0, 1'b1);
        idle(); drain();
        chk("results_seen", 128'(n_pop), 128'(n_push));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
